// File: rtl/mmio_uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package mmio_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [7:0] OFF_TXDATA = 8'd0;
  localparam logic [7:0] OFF_STATUS = 8'd1;

  localparam int BUSY  = 0;
  localparam int FULL  = 1;
  localparam int EMPTY = 2;
  localparam int OVF   = 3;

  function automatic logic [7:0] pack_status(input logic busy, input logic full,
                                             input logic empty, input logic ovf);
    logic [7:0] s;
    s        = 8'h00;
    s[BUSY]  = busy;
    s[FULL]  = full;
    s[EMPTY] = empty;
    s[OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous byte FIFO with a combinationally visible head entry.
module tx_fifo
  import mmio_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push,
  input  logic                                pop,
  input  logic [7:0]                          din,
  output logic [7:0]                          dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                full,
  output logic                                empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array write port.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register decode, TX FIFO and baud-timed shifter.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] w_data,
  input  logic       w_en,
  output logic       hit,
  output logic [7:0] r_data,
  output logic       tx
);

  localparam int                CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]        TXDATA_ADDR = BASE_ADDR + OFF_TXDATA;
  localparam logic [7:0]        STATUS_ADDR = BASE_ADDR + OFF_STATUS;

  logic              sel_data_s;
  logic              sel_status_s;
  logic              push_s;
  logic              pop_s;
  logic              tick_s;
  logic              ovf_set_s;
  logic              ovf_clr_s;
  logic [7:0]        status_s;
  logic [7:0]        fifo_dout_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  state_t            state_r;
  logic [BAUD_W-1:0] baud_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              ovf_r;
  logic              tx_r;

  assign sel_data_s   = (addr == TXDATA_ADDR);
  assign sel_status_s = (addr == STATUS_ADDR);
  assign push_s       = w_en && sel_data_s;
  assign ovf_clr_s    = w_en && sel_status_s;
  assign tick_s       = (baud_r == {BAUD_W{1'b0}});
  // The head leaves either from idle or straight out of a finishing stop bit.
  assign pop_s        = !fifo_empty_s && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && tick_s));
  assign ovf_set_s    = push_s && fifo_full_s && !pop_s;
  assign status_s     = pack_status(state_r != ST_IDLE,
                                    fifo_count_s == CNT_W'(FIFO_DEPTH),
                                    fifo_count_s == {CNT_W{1'b0}},
                                    ovf_r);
  assign tx           = tx_r;

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (w_data),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Read-port mux seen by the CPU alongside data memory.
  always_comb begin
    hit = sel_data_s || sel_status_s;
    if (sel_status_s) begin
      r_data = status_s;
    end else begin
      r_data = 8'h00;
    end
  end

  // Sticky overflow flag; a new overflow outranks a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= {BAUD_W{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (pop_s) begin
            shift_r <= fifo_dout_s;
            baud_r  <= BAUD_RELOAD;
            state_r <= ST_START;
            tx_r    <= 1'b0;
          end
        end
        ST_START: begin
          if (tick_s) begin
            state_r   <= ST_DATA;
            bit_idx_r <= 3'd0;
            baud_r    <= BAUD_RELOAD;
            tx_r      <= shift_r[0];
          end else begin
            baud_r <= baud_r - BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            baud_r <= BAUD_RELOAD;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r - BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (pop_s) begin
              shift_r <= fifo_dout_s;
              baud_r  <= BAUD_RELOAD;
              state_r <= ST_START;
              tx_r    <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_r <= baud_r - BAUD_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised scoreboard bench: a transaction-level model predicts accepted bytes and frame start times.
module tb_mmio_uart_tx;

  localparam logic [7:0] BASE   = 8'hF0;
  localparam logic [7:0] STAT_A = 8'hF1;
  localparam int         CPB    = 4;
  localparam int         DEPTH  = 4;
  localparam int         FRAME  = 10 * CPB;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] addr   = 8'hF1;
  logic [7:0] w_data = 8'h00;
  logic       w_en   = 1'b0;
  logic       hit;
  logic [7:0] r_data;
  logic       tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .w_data (w_data),
    .w_en   (w_en),
    .hit    (hit),
    .r_data (r_data),
    .tx     (tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         pop_cyc;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] model_q[$];
  int         cyc       = 0;
  int         next_free = 0;
  logic       m_ovf     = 1'b0;
  int         checks    = 0;
  int         errors    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [7:0] model_status();
    logic b, f, e;
    b = (cyc < next_free);
    f = (model_q.size() == DEPTH);
    e = (model_q.size() == 0);
    return {4'b0000, m_ovf, e, f, b};
  endfunction

  // Reference model: a transmitter takes the next byte once the previous frame's time is up.
  frame_t m_f;
  logic   m_set;
  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        model_q.delete();
        exp_q.delete();
        m_ovf     = 1'b0;
        next_free = 0;
      end else begin
        cyc++;
        m_set = 1'b0;
        if (model_q.size() > 0 && cyc >= next_free) begin
          m_f.data    = model_q.pop_front();
          m_f.pop_cyc = cyc;
          exp_q.push_back(m_f);
          next_free   = cyc + FRAME;
        end
        if (w_en && addr == BASE) begin
          if (model_q.size() < DEPTH) model_q.push_back(w_data);
          else m_set = 1'b1;
        end
        if (m_set) m_ovf = 1'b1;
        else if (w_en && addr == STAT_A) m_ovf = 1'b0;
      end
    end
  end

  // Monitor: decodes the serial line and checks each frame against the scoreboard.
  int         mcnt = 0;
  frame_t     cur;
  logic [7:0] rx;
  logic       lvl_err;
  logic       exp_lvl;
  int         slot;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        mcnt = 0;
      end else if (mcnt == 0) begin
        if (tx == 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_start", 32'(cyc), 32'hFFFF_FFFF);
            cur.data    = 8'h00;
            cur.pop_cyc = cyc;
          end else begin
            cur = exp_q.pop_front();
            chk("start_cycle", 32'(cyc), 32'(cur.pop_cyc));
          end
          mcnt    = 1;
          lvl_err = 1'b0;
          rx      = 8'h00;
        end else if (exp_q.size() > 0 && cyc > exp_q[0].pop_cyc) begin
          chk("missing_frame", 32'(tx), 32'h0);
          exp_q.delete(0);
        end
      end else begin
        slot = mcnt / CPB;
        if (slot == 0) exp_lvl = 1'b0;
        else if (slot == 9) exp_lvl = 1'b1;
        else exp_lvl = cur.data[slot-1];
        if (tx !== exp_lvl) lvl_err = 1'b1;
        if ((mcnt % CPB) == (CPB / 2) && slot >= 1 && slot <= 8) rx[slot-1] = tx;
        if (mcnt == FRAME - 1) begin
          chk("frame_byte", 32'(rx), 32'(cur.data));
          chk("frame_levels", 32'(lvl_err), 32'h0);
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  task automatic check_comb();
    logic       exp_hit;
    logic [7:0] exp_rd;
    exp_hit = (addr == BASE) || (addr == STAT_A);
    exp_rd  = (addr == STAT_A) ? model_status() : 8'h00;
    chk("hit", 32'(hit), 32'(exp_hit));
    chk("r_data", 32'(r_data), 32'(exp_rd));
  endtask

  task automatic cycle(input logic [7:0] a, input logic [7:0] d, input logic we);
    @(negedge clock);
    addr   = a;
    w_data = d;
    w_en   = we;
    #1;
    check_comb();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((model_q.size() > 0 || cyc < next_free || exp_q.size() > 0 || mcnt != 0) && k < 3000) begin
      cycle(STAT_A, 8'h00, 1'b0);
      k++;
    end
    chk("idle_timeout", 32'(k >= 3000), 32'h0);
  endtask

  task automatic reset_mid_frame(input logic [7:0] d, input int into);
    cycle(BASE, d, 1'b1);
    repeat (into) cycle(STAT_A, 8'h00, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_status", 32'(r_data), 32'h04);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (60) cycle(STAT_A, 8'h00, 1'b0);
  endtask

  int rate;
  int r;
  logic [7:0] ra;

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset_tx_init", 32'(tx), 32'h1);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Idle register reads.
    cycle(STAT_A, 8'h00, 1'b0);
    chk("idle_status", 32'(r_data), 32'h04);
    chk("idle_tx", 32'(tx), 32'h1);
    cycle(8'h10, 8'h00, 1'b0);
    chk("miss_hit", 32'(hit), 32'h0);
    cycle(BASE, 8'h00, 1'b0);

    // Single frame, then a back-to-back pair.
    cycle(BASE, 8'h55, 1'b1);
    wait_idle();
    cycle(BASE, 8'hA3, 1'b1);
    cycle(BASE, 8'h0F, 1'b1);
    wait_idle();

    // Overflow on the sixth store, then clear it.
    for (int i = 1; i <= 6; i++) cycle(BASE, 8'(i), 1'b1);
    cycle(STAT_A, 8'h00, 1'b0);
    chk("ovf_status", 32'(r_data), 32'h0B);
    cycle(STAT_A, 8'h77, 1'b1);
    cycle(STAT_A, 8'h00, 1'b0);
    chk("ovf_cleared", 32'(r_data[3]), 32'h0);
    wait_idle();

    // Clear followed immediately by a fresh overflow leaves the flag set.
    for (int i = 0; i < 6; i++) cycle(BASE, 8'(8'h30 + i), 1'b1);
    cycle(STAT_A, 8'h00, 1'b1);
    cycle(BASE, 8'h99, 1'b1);
    cycle(STAT_A, 8'h00, 1'b0);
    chk("ovf_reset_again", 32'(r_data[3]), 32'h1);
    wait_idle();

    // Reset in the middle of a frame aborts it.
    reset_mid_frame(8'hFF, 12);
    reset_mid_frame(8'h00, 2);

    // Random traffic with varying store density.
    for (int p = 0; p < 8; p++) begin
      rate = (p % 3 == 0) ? 5 : ((p % 3 == 1) ? 30 : 90);
      for (int c = 0; c < 100; c++) begin
        r = $urandom_range(0, 9);
        if (r < 5) ra = BASE;
        else if (r < 7) ra = STAT_A;
        else ra = 8'($urandom_range(0, 255));
        cycle(ra, 8'($urandom_range(0, 255)), ($urandom_range(0, 99) < rate));
      end
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that responds to CPU data-memory accesses. It uses the same address, write-data and write-enable signals the CPU drives into data memory. Stores to its data register queue bytes in a small FIFO, and a baud-timed shifter serialises them 8N1, LSB first. It returns status through a combinational read port, which the top level muxes against data memory using `hit`.

Parameters:
- BASE_ADDR, 8'hF0, address of TXDATA; STATUS is at BASE_ADDR+1.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥2.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2 and ≥2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  8  CPU data address.
- w_data  in  8  CPU store data.
- w_en  in  1  CPU store strobe, sampled on the rising edge of clock.
- hit  out  1  combinational; 1 when addr==BASE_ADDR or addr==BASE_ADDR+1.
- r_data  out  8  combinational read data; 8'h00 when hit==0.
- tx  out  1  serial line, registered; idle level 1.

Behaviour:
- Reset (async): tx=1, FIFO emptied, state=IDLE, baud counter=0, bit index=0, overflow=0.
  - r_data/hit are combinational; with idle addr they read STATUS=8'h04 after reset.
  - Reset mid-frame aborts the frame: tx returns to 1 immediately.
- Register map:
  - TXDATA (offset 0), write: push w_data. Read returns 8'h00.
  - STATUS (offset 1), read: {4'b0, overflow, fifo_empty, fifo_full, busy}.
    - bit0 busy = state!=IDLE.
    - bit1 full = count==FIFO_DEPTH.
    - bit2 empty = count==0.
    - bit3 overflow: sticky.
  - STATUS write (any data): clears overflow.
- Push rules:
  - Accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - If overflow set and STATUS-write clear land in the same cycle, set wins.
- Count width: $clog2(FIFO_DEPTH+1). Pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE, START, DATA, STOP. Baud counter reloads to CLKS_PER_BIT-1 on each state/bit entry and decrements; a "tick" is counter==0.
  - IDLE: if FIFO non-empty at an edge, then on that edge pop the head into the shift register, go to START, tx<=0.
  - START: on tick, go to DATA, bit index=0, tx<=shift[0].
  - DATA: on tick, shift right and increment bit index, tx<=next bit. After bit 7's tick, go to STOP, tx<=1.
  - STOP: on tick, if FIFO non-empty pop and go to START (tx<=0), back-to-back with no idle cycle. Otherwise go to IDLE, tx stays 1.
- Timing:
  - Store at edge N makes the FIFO non-empty after N; the pop and tx falling edge happen at edge N+1 if IDLE.
  - Frame length: exactly 10*CLKS_PER_BIT cycles from START entry to the next START or IDLE.
- Pop and push in the same cycle: both take effect; count unchanged.
- A push during START/DATA/STOP never disturbs the byte in flight.
- Reads have no side effects. w_en with hit==0 is ignored.

Decomposition:
- Package mmio_uart_pkg:
  - State enum.
  - Offsets OFF_TXDATA=0, OFF_STATUS=1.
  - STATUS bit indices BUSY=0, FULL=1, EMPTY=2, OVF=3.
- Sub-module tx_fifo (sync FIFO):
  - Parameter FIFO_DEPTH; 8-bit data.
  - Ports: clock, reset, push, pop, din, dout, count, full, empty.
  - Shows the head combinationally.
- Shifter, baud counter and register decode live in mmio_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=8'hF0):
- Reset then idle: read addr 8'hF1 → r_data=8'h04, hit=1, tx=1. Read addr 8'h10 → hit=0, r_data=8'h00.
- Store 8'h55 to 8'hF0 at edge N → tx=0 for cycles N+1..N+4, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles. busy=1 for exactly 40 cycles, then STATUS=8'h04.
- Store 8'hA3 then 8'h0F on consecutive cycles → two frames back-to-back (80 cycles total) with no idle cycle between the stop bit and the second start bit. Data bits are LSB first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Six stores on consecutive cycles (8'h01..8'h06) → first popped at the edge after store 1. Bytes 1–5 are transmitted, 6 is dropped; STATUS reads 8'h0B (full, busy, overflow) after store 6. Store to 8'hF1 then clears overflow.
- Reset asserted 12 cycles into a frame of 8'hFF → tx=1 asynchronously, STATUS=8'h04. No further frame is sent after reset deasserts.
- Overflow set and STATUS-write clear in the same cycle → overflow reads 1 afterwards.
